// File: rtl/elbeth_load_store_unit_pkg.sv
// Shared encodings and helpers for the elbeth memory stage: op codes, LSU
// states, alignment rules and store byte-lane steering.
package elbeth_load_store_unit_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    function automatic logic is_store(input logic [3:0] op);
        return op >= MEM_SB;
    endfunction

    // Codes above MEM_SW are unassigned and treated like MEM_NONE.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op != MEM_NONE) && (op <= MEM_SW);
    endfunction

    function automatic logic is_aligned(input logic [3:0] op, input logic [1:0] off);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return ~off[0];
            MEM_LW, MEM_SW:          return off == 2'b00;
            default:                 return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] off);
        case (op)
            MEM_SB:  return 4'b0001 << off;
            MEM_SH:  return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [3:0] op, input logic [31:0] d);
        case (op)
            MEM_SB:  return {4{d[7:0]}};
            MEM_SH:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/elbeth_load_align.sv
// Picks the addressed byte/half out of a read word and sign/zero extends it.
module elbeth_load_align
    import elbeth_load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [3:0]  op,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        result  = rdata;
        case (op)
            MEM_LB:  result = {{24{shifted[7]}}, shifted[7:0]};
            MEM_LBU: result = {24'h0, shifted[7:0]};
            MEM_LH:  result = {{16{shifted[15]}}, shifted[15:0]};
            MEM_LHU: result = {16'h0, shifted[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/elbeth_load_store_unit.sv
// Memory stage: issues one valid/ready data-memory transaction per EX memory
// op, stalls EX while it is outstanding and returns extended load data.
module elbeth_load_store_unit
    import elbeth_load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_flush,
    input  logic [3:0]        ex_mem_op,
    input  logic [ADDR_W-1:0] ex_address,
    input  logic [DATA_W-1:0] ex_store_data,
    output logic              stall,
    output logic              dmem_valid,
    input  logic              dmem_ready,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              exc_load_misaligned,
    output logic              exc_store_misaligned,
    output logic [ADDR_W-1:0] exc_addr
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              exc_ld_q, exc_ld_d;
    logic              exc_st_q, exc_st_d;
    logic [ADDR_W-1:0] exc_addr_q, exc_addr_d;
    logic              stall_c;
    logic              take_op;
    logic              aligned;
    logic [DATA_W-1:0] load_ext;

    elbeth_load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (addr_q[1:0]),
        .op     (op_q),
        .result (load_ext)
    );

    assign take_op = ex_valid && !ex_flush && is_mem_op(ex_mem_op);
    assign aligned = is_aligned(ex_mem_op, ex_address[1:0]);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        wb_data_d  = wb_data_q;
        exc_ld_d   = 1'b0;
        exc_st_d   = 1'b0;
        exc_addr_d = exc_addr_q;
        stall_c    = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (take_op && aligned) begin
                    state_d = LSU_BUSY;
                    addr_d  = ex_address;
                    we_d    = is_store(ex_mem_op);
                    be_d    = store_be(ex_mem_op, ex_address[1:0]);
                    wdata_d = store_wdata(ex_mem_op, ex_store_data);
                    op_d    = ex_mem_op;
                    stall_c = 1'b1;
                end else if (take_op) begin
                    exc_ld_d   = !is_store(ex_mem_op);
                    exc_st_d   = is_store(ex_mem_op);
                    exc_addr_d = ex_address;
                end
            end
            // Stall through the completing cycle too, so DONE still sees
            // the instruction that issued.
            LSU_BUSY: begin
                stall_c = 1'b1;
                if (dmem_ready) begin
                    state_d = LSU_DONE;
                    if (!we_q) wb_data_d = load_ext;
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LSU_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= 4'b0000;
            wdata_q    <= '0;
            op_q       <= 4'd0;
            wb_data_q  <= '0;
            exc_ld_q   <= 1'b0;
            exc_st_q   <= 1'b0;
            exc_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            wb_data_q  <= wb_data_d;
            exc_ld_q   <= exc_ld_d;
            exc_st_q   <= exc_st_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    // The IDLE issue path is combinational from EX, so hold stall low in reset.
    assign stall                = stall_c && rst_n;
    assign dmem_valid           = (state_q == LSU_BUSY);
    assign dmem_we              = we_q;
    assign dmem_addr            = {addr_q[ADDR_W-1:2], 2'b00};
    assign dmem_wdata           = wdata_q;
    assign dmem_be              = be_q;
    assign wb_valid             = (state_q == LSU_DONE) && !we_q;
    assign wb_data              = wb_data_q;
    assign exc_load_misaligned  = exc_ld_q;
    assign exc_store_misaligned = exc_st_q;
    assign exc_addr             = exc_addr_q;

endmodule
